multicycle_alu: RTL and testbench

//  Execute-stage ALU driven by the 3-bit ALUControl code from the ALU decoder.
//  ADD and SUB complete in one cycle. MUL and DIV are iterative: one bit per cycle.
//  A start/busy/done handshake lets the control unit stall the pipeline while MUL or DIV runs.

---
 rtl/alu_pkg.sv | 14 +
 rtl/alu_iter_divider.sv | 47 ++++
 rtl/multicycle_alu.sv | 121 ++++++++++++
 tb/tb_multicycle_alu.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode, state and flag-index definitions shared by the multicycle ALU.
package alu_pkg;
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_MUL = 3'b010;
    localparam logic [2:0] ALU_DIV = 3'b011;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} alu_state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;
endpackage

// File: rtl/alu_iter_divider.sv
// alu_iter_divider: unsigned restoring divider, one quotient bit per cycle.
// done is asserted in the last iteration cycle together with the final quotient.
module alu_iter_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem, quo, dv, rem_n;
    logic [WIDTH:0]   sh;
    logic             ge;

    // Partial remainder is always below the divisor, so WIDTH bits hold it after subtraction
    always_comb begin
        sh       = {rem, quo[WIDTH-1]};
        ge       = sh >= {1'b0, dv};
        rem_n    = ge ? sh[WIDTH-1:0] - dv : sh[WIDTH-1:0];
        quotient = {quo[WIDTH-2:0], ge};
        done     = cnt == CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            rem <= '0;
            quo <= '0;
            dv  <= '0;
        end else if (start) begin
            cnt <= CW'(WIDTH);
            rem <= '0;
            quo <= dividend;
            dv  <= divisor;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
            rem <= rem_n;
            quo <= quotient;
        end
    end
endmodule

// File: rtl/multicycle_alu.sv
// multicycle_alu: execute-stage ALU, single-cycle ADD/SUB, iterative MUL/DIV
// with start/busy/done handshake and registered result plus NZCV flags.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    alu_state_t         state, state_n;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   mcand, div_q, res_n;
    logic [2*WIDTH-1:0] prod, prod_n;
    logic [WIDTH:0]     psum, addsum, dif;
    logic [3:0]         flg_n;
    logic [2:0]         op;
    logic               accept, b_zero, div_start, div_done, load, c_n, v_n;

    always_comb begin
        op        = ALUControl[2] ? ALU_ADD : ALUControl;
        accept    = (state == IDLE) && start;
        b_zero    = b == '0;
        div_start = accept && (op == ALU_DIV) && !b_zero;
        psum      = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
        prod_n    = {psum, prod[WIDTH-1:1]};
        addsum    = {1'b0, a} + {1'b0, b};
        dif       = {1'b0, a} - {1'b0, b};
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (start) state_n = (op == ALU_MUL) ? MUL : div_start ? DIV : FIN;
            MUL:  if (cnt == CW'(1)) state_n = FIN;
            DIV:  if (div_done) state_n = FIN;
            FIN:  state_n = IDLE;
        endcase
    end

    // Result is captured on the edge that enters FIN
    always_comb begin
        load  = (accept && op != ALU_MUL && !div_start) ||
                (state == MUL && cnt == CW'(1)) || (state == DIV && div_done);
        res_n = addsum[WIDTH-1:0];
        c_n   = addsum[WIDTH];
        v_n   = (a[WIDTH-1] == b[WIDTH-1]) && (addsum[WIDTH-1] != a[WIDTH-1]);
        if (state == MUL) begin
            res_n = prod_n[WIDTH-1:0];
            c_n   = |prod_n[2*WIDTH-1:WIDTH];
            v_n   = c_n;
        end else if (state == DIV) begin
            res_n = div_q;
            c_n   = 1'b0;
            v_n   = 1'b0;
        end else if (op == ALU_SUB) begin
            res_n = dif[WIDTH-1:0];
            c_n   = ~dif[WIDTH];
            v_n   = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
        end else if (op == ALU_DIV) begin
            res_n = '1;
            c_n   = 1'b0;
            v_n   = 1'b0;
        end
        flg_n         = '0;
        flg_n[FLAG_N] = res_n[WIDTH-1];
        flg_n[FLAG_Z] = res_n == '0;
        flg_n[FLAG_C] = c_n;
        flg_n[FLAG_V] = v_n;
        busy          = state != IDLE;
        done          = state == FIN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            result      <= '0;
            flags       <= '0;
            div_by_zero <= 1'b0;
            cnt         <= '0;
            mcand       <= '0;
            prod        <= '0;
        end else begin
            state <= state_n;
            if (load) begin
                result <= res_n;
                flags  <= flg_n;
            end
            if (accept) begin
                div_by_zero <= (op == ALU_DIV) && b_zero;
                cnt         <= CW'(WIDTH);
                mcand       <= a;
                prod        <= {{WIDTH{1'b0}}, b};
            end else if (state == MUL) begin
                cnt  <= cnt - CW'(1);
                prod <= prod_n;
            end
        end
    end

    alu_iter_divider #(.WIDTH(WIDTH)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (a),
        .divisor  (b),
        .done     (div_done),
        .quotient (div_q)
    );
endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: randomized and directed checks of multicycle_alu against
// an arithmetic reference model.
module tb_multicycle_alu;
    logic        clk = 0, rst_n = 1, start = 0;
    logic [2:0]  ALUControl = 0;
    logic [31:0] a = 0, b = 0, result;
    logic [3:0]  flags;
    logic        busy, done, div_by_zero;
    int          n_checks = 0, n_fail = 0;

    multicycle_alu #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ALUControl(ALUControl),
        .a(a), .b(b), .result(result), .flags(flags), .busy(busy),
        .done(done), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic [2:0] op, input logic [31:0] x, y,
                                  output logic [31:0] r, output logic [3:0] f,
                                  output int lat, output logic z);
        logic [63:0] p;
        longint      s;
        z = 0; lat = 1; f = 0; r = 0; s = 0;
        case (op[2] ? 3'd0 : op)
            3'd0: begin
                r = x + y; f[1] = ({32'b0, x} + {32'b0, y}) > 64'hFFFF_FFFF;
                s = longint'($signed(x)) + longint'($signed(y));
                f[0] = s != longint'($signed(r));
            end
            3'd1: begin
                r = x - y; f[1] = x >= y;
                s = longint'($signed(x)) - longint'($signed(y));
                f[0] = s != longint'($signed(r));
            end
            3'd2: begin
                p = {32'b0, x} * {32'b0, y}; r = p[31:0];
                f[1] = p[63:32] != 0; f[0] = f[1]; lat = 33;
            end
            default: begin
                if (y == 0) begin r = 32'hFFFF_FFFF; z = 1; end
                else begin r = x / y; lat = 33; end
            end
        endcase
        f[3] = r[31];
        f[2] = r == 0;
    endfunction

    // Launch one op, scramble inputs afterwards, and measure latency to done.
    // hs reports whether busy/result behaved during the wait and done was a single pulse.
    task automatic run_op(input logic [2:0] op, input logic [31:0] x, y, output int lat,
                          output logic [31:0] r, output logic [3:0] f, output logic z,
                          output logic hs);
        logic [31:0] r0;
        r0 = result;
        @(negedge clk);
        ALUControl = op; a = x; b = y; start = 1;
        @(negedge clk);
        start = 0; a = $urandom; b = $urandom; ALUControl = 3'($urandom);
        lat = 1; hs = 1;
        while (!done && lat < 100) begin
            if (!busy || result !== r0) hs = 0;
            @(negedge clk);
            lat++;
        end
        r = result; f = flags; z = div_by_zero;
        if (!busy) hs = 0;
        @(negedge clk);
        if (busy || done) hs = 0;
    endtask

    task automatic test_reset();
        int lat, nd;
        logic [31:0] r;
        logic [3:0] f;
        logic z, hs;
        #1 rst_n = 0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({result, flags, busy, done, div_by_zero} !== 39'b0) begin
            n_fail++;
            $display("FAIL reset_state: got %h/%h/%b%b%b want 0", result, flags, busy, done, div_by_zero);
        end
        rst_n = 1;
        run_op(3'b011, 32'd5, 32'd0, lat, r, f, z, hs);
        @(negedge clk);
        ALUControl = 3'b010; a = 7; b = 9; start = 1;
        @(negedge clk);
        start = 0;
        repeat (4) @(negedge clk);
        rst_n = 0;
        #1;
        n_checks++;
        if ({result, flags, busy, done, div_by_zero} !== 39'b0) begin
            n_fail++;
            $display("FAIL reset_mid_mul: got %h/%h/%b%b%b want 0", result, flags, busy, done, div_by_zero);
        end
        @(negedge clk);
        rst_n = 1;
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) nd++;
        end
        n_checks++;
        if (nd !== 0) begin n_fail++; $display("FAIL reset_no_done: got %0d dones want 0", nd); end
        run_op(3'b000, 32'd20, 32'd22, lat, r, f, z, hs);
        n_checks++;
        if (r !== 32'd42 || lat !== 1) begin
            n_fail++;
            $display("FAIL reset_restart: got %0d lat %0d want 42 lat 1", r, lat);
        end
    endtask

    task automatic check_vectors(input string name, input logic [2:0] op,
                                 input logic [31:0] xs[$], input logic [31:0] ys[$]);
        int lat, elat;
        logic [31:0] r, er;
        logic [3:0] f, ef;
        logic z, ez, hs;
        foreach (xs[i]) begin
            model(op, xs[i], ys[i], er, ef, elat, ez);
            run_op(op, xs[i], ys[i], lat, r, f, z, hs);
            n_checks++;
            if (lat !== elat || r !== er || f !== ef || z !== ez || hs !== 1'b1) begin
                n_fail++;
                $display("FAIL %s op%0d a=%h b=%h: got r=%h f=%b dbz=%b lat=%0d hs=%b want r=%h f=%b dbz=%b lat=%0d hs=1",
                         name, op, xs[i], ys[i], r, f, z, lat, hs, er, ef, ez, elat);
            end
        end
    endtask

    task automatic test_add_sub();
        logic [31:0] xs[$], ys[$];
        xs = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
        ys = '{32'd1, 32'd1, 32'h8000_0000};
        repeat (8) begin xs.push_back($urandom); ys.push_back($urandom); end
        check_vectors("add", 3'b000, xs, ys);
        xs = '{32'd5, 32'd0, 32'h8000_0000, 32'h7FFF_FFFF};
        ys = '{32'd5, 32'd1, 32'd1, 32'hFFFF_FFFF};
        repeat (8) begin xs.push_back($urandom); ys.push_back($urandom); end
        check_vectors("sub", 3'b001, xs, ys);
    endtask

    task automatic test_mul();
        logic [31:0] xs[$], ys[$];
        xs = '{32'd12, 32'h0001_0000, 32'hFFFF_FFFF, 32'd0};
        ys = '{32'd11, 32'h0001_0000, 32'hFFFF_FFFF, 32'h1234_5678};
        repeat (6) begin xs.push_back($urandom); ys.push_back($urandom >> $urandom_range(0, 31)); end
        check_vectors("mul", 3'b010, xs, ys);
    endtask

    task automatic test_div();
        logic [31:0] xs[$], ys[$];
        xs = '{32'd100, 32'd5, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF};
        ys = '{32'd7, 32'd0, 32'd1, 32'd10, 32'hFFFF_FFFF};
        repeat (6) begin xs.push_back($urandom); ys.push_back($urandom >> $urandom_range(0, 31)); end
        check_vectors("div", 3'b011, xs, ys);
    endtask

    task automatic test_alu_ctrl_1xx();
        logic [31:0] xs[$], ys[$];
        xs = '{32'd3, 32'hFFFF_FFF0};
        ys = '{32'd4, 32'h20};
        check_vectors("ctrl110", 3'b110, xs, ys);
        check_vectors("ctrl111", 3'b111, xs, ys);
    endtask

    task automatic test_start_held();
        int i;
        @(negedge clk);
        ALUControl = 3'b010; a = 3; b = 5; start = 1;
        @(negedge clk);
        i = 1;
        while (!done && i < 60) begin
            if (i == 3) begin a = $urandom; b = $urandom; end
            @(negedge clk);
            i++;
        end
        n_checks++;
        if (i !== 33 || result !== 32'd15) begin
            n_fail++;
            $display("FAIL held_mul: got r=%0d lat=%0d want r=15 lat=33", result, i);
        end
        ALUControl = 3'b000; a = 10; b = 20;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL held_gap: got done=%b busy=%b want 0 0", done, busy);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || result !== 32'd30) begin
            n_fail++;
            $display("FAIL held_next: got done=%b r=%0d want 1 30", done, result);
        end
        start = 0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat, elat;
        logic [31:0] r, er, x, y;
        logic [3:0] f, ef;
        logic [2:0] op;
        logic z, ez, hs;
        repeat (12) begin
            op = 3'($urandom_range(0, 7));
            x = $urandom;
            y = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
            model(op, x, y, er, ef, elat, ez);
            run_op(op, x, y, lat, r, f, z, hs);
            n_checks++;
            if (lat !== elat || r !== er || f !== ef || z !== ez || hs !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b op%0d a=%h b=%h: got r=%h f=%b dbz=%b lat=%0d hs=%b want r=%h f=%b dbz=%b lat=%0d",
                         op, x, y, r, f, z, lat, hs, er, ef, ez, elat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_mul();
        test_div();
        test_alu_ctrl_1xx();
        test_start_held();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
